vga_layer_mixer: RTL and testbench

Downstream compositor for the player sprite stage: takes the sprite's bounding box and ROM pixel, plus the background ROM pixel and VGA timing, and produces the final 12-bit RGB and syncs. It aligns VGA timing with ROM read latency, keys out a transparent colour, and latches sprite borders once per frame so that a mid-frame move cannot tear the sprite. It also reports frame completion and whether the sprite was visible.

---
 rtl/vga_layer_mixer.sv | 170 +++++++++++++++++
 tb/tb_vga_layer_mixer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_mixer.sv
// Final-stage compositor: keys the sprite over the background and aligns VGA timing with ROM latency.
// Optional LAYER_SHADOW_EN latches the sprite box once per frame so that a mid-frame move cannot tear it.
module vga_layer_mixer #(
    parameter logic [11:0] KEY_COLOR = 12'hF0F,
    parameter int          ROM_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  spr_left,
    input  logic [9:0]  spr_right,
    input  logic [9:0]  spr_up,
    input  logic [9:0]  spr_down,
    input  logic [11:0] spr_pixel,
    input  logic [11:0] bg_pixel,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_done,
    output logic        spr_visible
);
    typedef enum logic [1:0] {WAIT, ACTIVE, BLANK} state_t;

    state_t state_reg, state_next;
    logic   at_origin, at_end, go_active, go_blank;

    assign at_origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign at_end    = (h_cnt == 10'd0) && (v_cnt == 10'd480);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= WAIT;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        go_active  = 1'b0;
        go_blank   = 1'b0;
        case (state_reg)
            WAIT, BLANK: begin
                if (pix_ce && at_origin) begin
                    state_next = ACTIVE;
                    go_active  = 1'b1;
                end
            end
            ACTIVE: begin
                if (pix_ce && at_end) begin
                    state_next = BLANK;
                    go_blank   = 1'b1;
                end
            end
            default: state_next = WAIT;
        endcase
    end

    logic [9:0] box_l, box_r, box_u, box_d;
`ifdef LAYER_SHADOW_EN
    logic [9:0] sh_l_reg, sh_r_reg, sh_u_reg, sh_d_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_l_reg <= '0;
            sh_r_reg <= '0;
            sh_u_reg <= '0;
            sh_d_reg <= '0;
        end else if (go_active) begin
            sh_l_reg <= spr_left;
            sh_r_reg <= spr_right;
            sh_u_reg <= spr_up;
            sh_d_reg <= spr_down;
        end
    end

    // The first pixel of a frame already belongs to the newly latched box.
    assign box_l = go_active ? spr_left  : sh_l_reg;
    assign box_r = go_active ? spr_right : sh_r_reg;
    assign box_u = go_active ? spr_up    : sh_u_reg;
    assign box_d = go_active ? spr_down  : sh_d_reg;
`else
    assign box_l = spr_left;
    assign box_r = spr_right;
    assign box_u = spr_up;
    assign box_d = spr_down;
`endif

    // An inverted box (left>right or up>down) matches nothing, which hides wrapped sprites.
    logic in_box_now;
    assign in_box_now = valid && (box_l <= h_cnt) && (h_cnt <= box_r)
                              && (box_u <= v_cnt) && (v_cnt <= box_d);

    logic [ROM_LAT-1:0] in_box_dly_reg, valid_dly_reg, hs_dly_reg, vs_dly_reg;
    logic [ROM_LAT:0]   in_box_chain, valid_chain, hs_chain, vs_chain;

    assign in_box_chain = {in_box_dly_reg, in_box_now};
    assign valid_chain  = {valid_dly_reg, valid};
    assign hs_chain     = {hs_dly_reg, hsync_in};
    assign vs_chain     = {vs_dly_reg, vsync_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            in_box_dly_reg <= '0;
            valid_dly_reg  <= '0;
            hs_dly_reg     <= '1;
            vs_dly_reg     <= '1;
        end else if (pix_ce) begin
            in_box_dly_reg <= in_box_chain[ROM_LAT-1:0];
            valid_dly_reg  <= valid_chain[ROM_LAT-1:0];
            hs_dly_reg     <= hs_chain[ROM_LAT-1:0];
            vs_dly_reg     <= vs_chain[ROM_LAT-1:0];
        end
    end

    logic        draw;
    logic [11:0] color_next;
    logic [11:0] color_reg;
    logic        hsync_reg, vsync_reg, frame_done_reg, spr_visible_reg, seen_reg;

    assign draw = in_box_dly_reg[ROM_LAT-1] && valid_dly_reg[ROM_LAT-1]
               && (spr_pixel != KEY_COLOR) && (state_reg != WAIT);

    always_comb begin
        color_next = 12'h000;
        if ((state_reg != WAIT) && valid_dly_reg[ROM_LAT-1])
            color_next = draw ? spr_pixel : bg_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_reg <= 12'h000;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else if (pix_ce) begin
            color_reg <= color_next;
            hsync_reg <= hs_dly_reg[ROM_LAT-1];
            vsync_reg <= vs_dly_reg[ROM_LAT-1];
        end
    end

    // Frame start clears before any same-tick pixel can set; frame end folds in the last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_reg        <= 1'b0;
            spr_visible_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            frame_done_reg <= go_blank;
            if (go_active)
                seen_reg <= 1'b0;
            else if (pix_ce && draw)
                seen_reg <= 1'b1;
            if (go_blank)
                spr_visible_reg <= seen_reg | draw;
        end
    end

    assign vga_r       = color_reg[11:8];
    assign vga_g       = color_reg[7:4];
    assign vga_b       = color_reg[3:0];
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign frame_done  = frame_done_reg;
    assign spr_visible = spr_visible_reg;
endmodule

// File: tb/tb_vga_layer_mixer.sv
// Bench for vga_layer_mixer: compressed VGA scans drive two instances (ROM_LAT 1 and 3)
// against a per-pixel reference built from the compositing rules.
module tb_vga_layer_mixer;
    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst, pix_ce, valid, hsync_in, vsync_in;
    logic [9:0]  h_cnt, v_cnt, spr_left, spr_right, spr_up, spr_down;
    logic [11:0] spr_pix [2];
    logic [11:0] bg_pix  [2];
    logic [3:0]  vr [2];
    logic [3:0]  vg [2];
    logic [3:0]  vb [2];
    logic        hs [2];
    logic        vs [2];
    logic        fd [2];
    logic        sv [2];

    always #5 clk = ~clk;

    vga_layer_mixer #(.KEY_COLOR(KEY), .ROM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .valid(valid), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .spr_left(spr_left), .spr_right(spr_right), .spr_up(spr_up), .spr_down(spr_down),
        .spr_pixel(spr_pix[0]), .bg_pixel(bg_pix[0]),
        .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]), .hsync(hs[0]), .vsync(vs[0]),
        .frame_done(fd[0]), .spr_visible(sv[0]));

    vga_layer_mixer #(.KEY_COLOR(KEY), .ROM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .valid(valid), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .spr_left(spr_left), .spr_right(spr_right), .spr_up(spr_up), .spr_down(spr_down),
        .spr_pixel(spr_pix[1]), .bg_pixel(bg_pix[1]),
        .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1]), .hsync(hs[1]), .vsync(vs[1]),
        .frame_done(fd[1]), .spr_visible(sv[1]));

    typedef struct {
        logic        valid;
        logic        hs;
        logic        vs;
        logic        opaque;
        logic [11:0] spr;
        logic [11:0] bg;
        logic [11:0] col;
    } pix_t;

    pix_t        hist [8];
    int          checks = 0;
    int          errors = 0;
    int          k;
    int          phase;          // 0: not yet synced, 1: inside a frame, 2: between frames
    logic        acc [2];
    logic        exp_vis [2];
    logic [11:0] exp_col [2];
    int          cap_l, cap_r, cap_u, cap_d;
    int          spr_mode;       // 0: fixed colour, 1: all key, 2: random with key mix
    logic [11:0] spr_fix, bg_fix;
    logic        bg_rand;
    int          chg_row;
    logic [9:0]  chg_left;
    int          rows [23] = '{0, 1, 100, 200, 239, 240, 241, 250, 260, 261, 270, 279,
                              280, 300, 400, 478, 479, 480, 481, 490, 491, 500, 524};
    int          cols [19] = '{0, 1, 13, 100, 319, 320, 321, 325, 330, 355, 359, 360,
                              500, 638, 639, 640, 656, 700, 799};

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input int inst, input logic [11:0] obs,
                         input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lat=%0d pixel#%0d observed=%h expected=%h", tag, lat(inst), k, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++)
            hist[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 12'h000};
        phase = 0;
        k     = 8;
        for (int i = 0; i < 2; i++) begin
            acc[i]     = 1'b0;
            exp_vis[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        pix_ce = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 2; i++) begin
            check("rst_rgb", i, {vr[i], vg[i], vb[i]}, 12'h000);
            check("rst_hsync", i, 12'(hs[i]), 12'h001);
            check("rst_vsync", i, 12'(vs[i]), 12'h001);
            check("rst_frame_done", i, 12'(fd[i]), 12'h000);
            check("rst_spr_visible", i, 12'(sv[i]), 12'h000);
        end
    endtask

    task automatic step(input int h, input int v);
        pix_t p, o;
        int   bl, br, bu, bd;
        logic starting, ending, waiting, drawn;
        starting = (h == 0) && (v == 0) && (phase != 1);
        ending   = (h == 0) && (v == 480) && (phase == 1);
        if (starting) begin
            cap_l = int'(spr_left);
            cap_r = int'(spr_right);
            cap_u = int'(spr_up);
            cap_d = int'(spr_down);
        end
`ifdef LAYER_SHADOW_EN
        bl = cap_l; br = cap_r; bu = cap_u; bd = cap_d;
`else
        bl = int'(spr_left); br = int'(spr_right); bu = int'(spr_up); bd = int'(spr_down);
`endif
        p.valid = (h < 640) && (v < 480);
        p.hs    = !((h >= 656) && (h < 752));
        p.vs    = !((v == 490) || (v == 491));
        if (spr_mode == 0)      p.spr = spr_fix;
        else if (spr_mode == 1) p.spr = KEY;
        else                    p.spr = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
        p.bg     = bg_rand ? 12'($urandom) : bg_fix;
        p.opaque = p.valid && (h >= bl) && (h <= br) && (v >= bu) && (v <= bd) && (p.spr != KEY);
        p.col    = !p.valid ? 12'h000 : (p.opaque ? p.spr : p.bg);
        hist[k % 8] = p;

        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        valid    = p.valid;
        hsync_in = p.hs;
        vsync_in = p.vs;
        pix_ce   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            spr_pix[i] = hist[(k - lat(i)) % 8].spr;
            bg_pix[i]  = hist[(k - lat(i)) % 8].bg;
        end
        @(posedge clk);
        #1;
        waiting = (phase == 0);
        for (int i = 0; i < 2; i++) begin
            o          = hist[(k - lat(i)) % 8];
            exp_col[i] = waiting ? 12'h000 : o.col;
            drawn      = !waiting && o.opaque;
            if (starting) acc[i] = 1'b0;
            else begin
                if (ending) exp_vis[i] = acc[i] | drawn;
                acc[i] = acc[i] | drawn;
            end
            check("rgb", i, {vr[i], vg[i], vb[i]}, exp_col[i]);
            check("hsync", i, 12'(hs[i]), 12'(o.hs));
            check("vsync", i, 12'(vs[i]), 12'(o.vs));
            check("frame_done", i, 12'(fd[i]), 12'(ending));
            check("spr_visible", i, 12'(sv[i]), 12'(exp_vis[i]));
        end
        if (starting)    phase = 1;
        else if (ending) phase = 2;
        k++;

        pix_ce = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rgb_hold", i, {vr[i], vg[i], vb[i]}, exp_col[i]);
            check("frame_done_width", i, 12'(fd[i]), 12'h000);
        end
    endtask

    task automatic scan(input int from_v, input int to_v);
        for (int ri = 0; ri < 23; ri++) begin
            if (rows[ri] >= from_v && rows[ri] <= to_v) begin
                for (int ci = 0; ci < 19; ci++) begin
                    if (rows[ri] == chg_row && ci == 0) spr_left = chg_left;
                    step(cols[ci], rows[ri]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; pix_ce = 1'b0; h_cnt = '0; v_cnt = 10'd524; valid = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        spr_left = 10'd320; spr_right = 10'd359; spr_up = 10'd240; spr_down = 10'd279;
        spr_pix[0] = '0; spr_pix[1] = '0; bg_pix[0] = '0; bg_pix[1] = '0;
        spr_mode = 0; spr_fix = 12'hABC; bg_fix = 12'h123; bg_rand = 1'b0;
        chg_row = -1; chg_left = 10'd320;
        cap_l = 0; cap_r = 0; cap_u = 0; cap_d = 0;
        clear_model();
        do_reset();

        // Opaque sprite over a flat background.
        scan(0, 524);
        for (int i = 0; i < 2; i++) check("visible_after_opaque_frame", i, 12'(sv[i]), 12'h001);

        // Sprite entirely key colour.
        spr_mode = 1;
        scan(0, 524);
        for (int i = 0; i < 2; i++) check("visible_after_keyed_frame", i, 12'(sv[i]), 12'h000);

        // Left edge moved mid-frame, then one frame with the new edge.
        spr_mode = 0;
        chg_row  = 260;
        chg_left = 10'd330;
        scan(0, 524);
        chg_row = -1;
        scan(0, 524);

        // Wrapped box hides the sprite.
        spr_left = 10'd1022; spr_right = 10'd13;
        scan(0, 524);
        for (int i = 0; i < 2; i++) check("visible_after_wrapped_frame", i, 12'(sv[i]), 12'h000);

        // Randomised boxes, colours and mid-frame moves.
        spr_mode = 2;
        bg_rand  = 1'b1;
        repeat (6) begin
            spr_left  = 10'($urandom_range(0, 700));
            spr_right = 10'($urandom_range(0, 800));
            spr_up    = 10'($urandom_range(0, 500));
            spr_down  = 10'($urandom_range(0, 500));
            chg_row   = ($urandom_range(0, 1) == 0) ? -1 : rows[$urandom_range(1, 16)];
            chg_left  = 10'($urandom_range(0, 700));
            scan(0, 524);
        end
        chg_row = -1;

        // Reset mid-frame: blank until the next frame start, no spurious frame_done.
        spr_left = 10'd0; spr_right = 10'd639; spr_up = 10'd0; spr_down = 10'd479;
        scan(0, 100);
        do_reset();
        scan(101, 524);
        scan(0, 524);
        for (int i = 0; i < 2; i++) check("visible_after_reset_frame", i, 12'(sv[i]), 12'(exp_vis[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
